// File: rtl/fsk_transmitter.sv
// fsk_transmitter: frames valid/ready bytes into preamble+start/8N/stop+tail bursts
// and keys a continuous-phase FSK NCO phase accumulator. Rev 1.0
`default_nettype none

module fsk_transmitter #(
  parameter int unsigned BIT_CYCLES    = 1300,
  parameter logic [31:0] MARK_INC      = 32'd483183821,
  parameter logic [31:0] SPACE_INC     = 32'd450000000,
  parameter int unsigned PREAMBLE_BITS = 16,
  parameter int unsigned TAIL_BITS     = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  data,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        tx_en,
  output logic        bit_out,
  output logic [31:0] phase_inc,
  output logic [31:0] phase,
  output logic        busy
);

  localparam int unsigned TMR_W   = $clog2(BIT_CYCLES);
  localparam int unsigned CNT_MAX = (PREAMBLE_BITS > TAIL_BITS) ?
                                    ((PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8) :
                                    ((TAIL_BITS > 8) ? TAIL_BITS : 8);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(7);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_START    = 3'd2,
    S_DATA     = 3'd3,
    S_STOP     = 3'd4,
    S_TAIL     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              bit_q, bit_d;
  logic              ready_q, ready_d;
  logic              txen_q, txen_d;
  logic [31:0]       inc_q, inc_d;
  logic [31:0]       phase_q, phase_d;
  logic              take;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= 1'b1;
      ready_q <= 1'b0;
      txen_q  <= 1'b0;
      inc_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      ready_q <= ready_d;
      txen_q  <= txen_d;
      inc_q   <= inc_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    take    = ready_q && data_valid;

    if (state_q == S_IDLE) begin
      if (take) begin
        state_d = S_PREAMBLE;
        timer_d = TMR_LOAD;
        cnt_d   = '0;
        shift_d = data;
        bit_d   = 1'b1;
      end
    end else if (timer_q != '0) begin
      timer_d = timer_q - TMR_W'(1);
    end else begin
      timer_d = TMR_LOAD;
      case (state_q)
        S_PREAMBLE: begin
          if (cnt_q == PRE_LAST) begin
            state_d = S_START;
            bit_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            bit_d = ~bit_q;
          end
        end
        S_START: begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = shift_q[0];
        end
        S_DATA: begin
          if (cnt_q == DATA_LAST) begin
            state_d = S_STOP;
            bit_d   = 1'b1;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = shift_q[1];
          end
        end
        S_STOP: begin
          // Back-to-back bytes skip the preamble and tail entirely.
          if (take) begin
            state_d = S_START;
            shift_d = data;
            bit_d   = 1'b0;
          end else begin
            state_d = S_TAIL;
            cnt_d   = '0;
            bit_d   = 1'b1;
          end
        end
        S_TAIL: begin
          bit_d = 1'b1;
          if (cnt_q == TAIL_LAST) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          bit_d   = 1'b1;
        end
      endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
    txen_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE) || ((state_d == S_STOP) && (timer_d == '0));
    inc_d   = txen_d ? (bit_d ? MARK_INC : SPACE_INC) : 32'd0;
    phase_d = txen_d ? (phase_q + inc_q) : 32'd0;
  end

  assign data_ready = ready_q;
  assign tx_en      = txen_q;
  assign busy       = txen_q;
  assign bit_out    = bit_q;
  assign phase_inc  = inc_q;
  assign phase      = phase_q;

endmodule

`default_nettype wire

// File: tb/tb_fsk_transmitter.sv
// tb_fsk_transmitter: directed and randomized bursts checked cycle-by-cycle against
// a symbol-queue reference model of the FSK framer. Rev 1.0
`default_nettype none

module tb_fsk_transmitter;

  localparam int          BC    = 4;
  localparam int          PRE   = 4;
  localparam int          TAIL  = 2;
  localparam logic [31:0] MARK  = 32'h4000_0000;
  localparam logic [31:0] SPACE = 32'h2000_0000;

  logic        clock;
  logic        reset_n;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_ready;
  logic        tx_en;
  logic        bit_out;
  logic [31:0] phase_inc;
  logic [31:0] phase;
  logic        busy;

  fsk_transmitter #(
    .BIT_CYCLES   (BC),
    .MARK_INC     (MARK),
    .SPACE_INC    (SPACE),
    .PREAMBLE_BITS(PRE),
    .TAIL_BITS    (TAIL)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .data      (data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .tx_en     (tx_en),
    .bit_out   (bit_out),
    .phase_inc (phase_inc),
    .phase     (phase),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp;
  int n_mis;
  int txen_cnt;

  // Reference model: queue of pending symbols, {bit value, is-stop-bit}.
  logic [1:0]  symq[$];
  bit          m_active;
  int          m_cyc;
  logic [31:0] m_phase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    symq.push_back(2'b00);
    for (int i = 0; i < 8; i++) symq.push_back({d[i], 1'b0});
    symq.push_back(2'b11);
  endtask

  task automatic do_reset();
    data_valid = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_bit_out", 32'(bit_out), 32'd1);
    chk("rst_phase_inc", phase_inc, 32'd0);
    chk("rst_phase", phase, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    symq.delete();
    m_active = 0;
    m_cyc    = 0;
    m_phase  = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One clock: check this cycle's outputs, drive inputs, advance the model.
  task automatic run_cycle(input logic v, input logic [7:0] d, output logic acc);
    logic        e_ready, e_bit, e_tx;
    logic [31:0] e_inc;
    logic [1:0]  s;
    @(negedge clock);
    if (m_active) begin
      e_tx    = 1'b1;
      e_bit   = symq[0][1];
      e_ready = symq[0][0] && (m_cyc == BC - 1);
      e_inc   = e_bit ? MARK : SPACE;
    end else begin
      e_tx    = 1'b0;
      e_bit   = 1'b1;
      e_ready = 1'b1;
      e_inc   = '0;
    end
    chk("tx_en", 32'(tx_en), 32'(e_tx));
    chk("busy", 32'(busy), 32'(e_tx));
    chk("bit_out", 32'(bit_out), 32'(e_bit));
    chk("data_ready", 32'(data_ready), 32'(e_ready));
    chk("phase_inc", phase_inc, e_inc);
    chk("phase", phase, m_phase);
    if (tx_en) txen_cnt++;
    data_valid = v;
    data       = d;
    acc        = e_ready && v;
    if (!m_active) begin
      if (acc) begin
        m_active = 1;
        m_cyc    = 0;
        m_phase  = '0;
        for (int i = 0; i < PRE; i++) symq.push_back({(i % 2 == 0) ? 1'b1 : 1'b0, 1'b0});
        push_frame(d);
      end
    end else begin
      m_phase = m_phase + e_inc;
      m_cyc++;
      if (m_cyc == BC) begin
        m_cyc = 0;
        s = symq.pop_front();
        if (s[0]) begin
          if (acc) push_frame(d);
          else for (int i = 0; i < TAIL; i++) symq.push_back(2'b10);
        end
        if (symq.size() == 0) begin
          m_active = 0;
          m_phase  = '0;
        end
      end
    end
  endtask

  task automatic drain();
    logic dummy;
    int   n;
    n = 0;
    while ((m_active || tx_en) && n < 400) begin
      run_cycle(1'b0, 8'($urandom), dummy);
      n++;
    end
    chk("drain_idle", 32'(tx_en), 32'd0);
  endtask

  task automatic send_until_accepted(input logic [7:0] d0, input logic [7:0] d1);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      run_cycle(1'b1, (m_active ? symq[0][0] : 1'b0) ? d1 : d0, acc);
      n++;
    end
    chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  logic dmy;

  initial begin
    n_cmp      = 0;
    n_mis      = 0;
    txen_cnt   = 0;
    reset_n    = 1'b1;
    data_valid = 1'b0;
    data       = '0;
    #2;
    do_reset();

    // Single byte: full preamble, frame and tail
    txen_cnt = 0;
    run_cycle(1'b1, 8'hA5, dmy);
    drain();
    chk("burst_len_A5", 32'(txen_cnt), 32'd64);

    // Two bytes back-to-back with valid held
    txen_cnt = 0;
    run_cycle(1'b1, 8'h00, dmy);
    send_until_accepted(8'hFF, 8'hFF);
    drain();
    chk("burst_len_00FF", 32'(txen_cnt), 32'd104);

    // Reset in the middle of data bit 3 of 0x3C
    run_cycle(1'b1, 8'h3C, dmy);
    repeat (34) run_cycle(1'b0, 8'h00, dmy);
    @(posedge clock);
    #1;
    do_reset();
    txen_cnt = 0;
    run_cycle(1'b1, 8'h81, dmy);
    drain();
    chk("burst_len_81", 32'(txen_cnt), 32'd64);

    // Data changes while not ready: only the value at the ready cycle counts
    txen_cnt = 0;
    run_cycle(1'b1, 8'h5A, dmy);
    send_until_accepted(8'h11, 8'h22);
    drain();
    chk("burst_len_5A22", 32'(txen_cnt), 32'd104);

    // Randomized valid/data traffic
    for (int i = 0; i < 2000; i++) begin
      run_cycle(($urandom_range(0, 3) != 0), 8'($urandom), dmy);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
